// File: rtl/ps2_kbd_tx_pkg.sv
// ps2_kbd_tx_pkg: shared FSM states, PS/2 frame constants and frame-bit helpers
package ps2_kbd_tx_pkg;

    typedef enum logic [2:0] {IDLE, BIT_HI, BIT_LO, GAP, HOLD} state_t;

    localparam int         FRAME_BITS = 11;
    localparam logic       START_BIT  = 1'b0;
    localparam logic       STOP_BIT   = 1'b1;
    localparam int         PARITY_IDX = 9;
    localparam logic [3:0] LAST_IDX   = 4'(FRAME_BITS - 1);

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] i);
        logic [FRAME_BITS-1:0] f;
        f                = '1;
        f[0]             = START_BIT;
        f[8:1]           = d;
        f[PARITY_IDX]    = odd_parity(d);
        f[FRAME_BITS-1]  = STOP_BIT;
        return f[i];
    endfunction

endpackage

// File: rtl/ps2_kbd_tx_fifo.sv
// ps2_kbd_tx_fifo: synchronous byte FIFO holding queued scancodes
module ps2_kbd_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 wr_data,
    input  logic                       pop,
    output logic [7:0]                 rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign rd_data = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // pointer, storage and occupancy update; push blocked while full even if popping
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: device-side PS/2 keyboard transmitter with byte FIFO
module ps2_kbd_tx
    import ps2_kbd_tx_pkg::*;
#(
    parameter int CLK_DIV    = 1667,
    parameter int GAP_CYCLES = 3334,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            inhibit,
    output logic                            ps2_clk,
    output logic                            ps2_data,
    output logic                            busy,
    output logic                            frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
    localparam int CMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DONE_AT  = CW'(CLK_DIV - 2);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    state_t        state;
    logic [3:0]    idx;
    logic [CW-1:0] cnt;
    logic [7:0]    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          abort;

    assign in_ready = ~fifo_full;
    assign busy     = state != IDLE;
    assign pop      = (state == BIT_LO) && (idx == LAST_IDX) && (cnt == DIV_LAST);
    assign abort    = inhibit && (state == BIT_HI || state == BIT_LO) && (idx != LAST_IDX);

    ps2_kbd_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // frame sequencer: divider, bit index and registered line drivers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            ps2_clk    <= 1'b1;
            ps2_data   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == BIT_LO) && (idx == LAST_IDX) && (cnt == DONE_AT);
            if (abort) begin
                state    <= HOLD;
                cnt      <= '0;
                ps2_clk  <= 1'b1;
                ps2_data <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (!fifo_empty && !inhibit) begin
                        state    <= BIT_HI;
                        idx      <= '0;
                        cnt      <= '0;
                        ps2_data <= frame_bit(head, 4'd0);
                    end
                    BIT_HI: if (cnt == DIV_LAST) begin
                        state   <= BIT_LO;
                        cnt     <= '0;
                        ps2_clk <= 1'b0;
                    end else cnt <= cnt + 1'b1;
                    BIT_LO: if (cnt == DIV_LAST) begin
                        cnt     <= '0;
                        ps2_clk <= 1'b1;
                        if (idx == LAST_IDX) begin
                            state    <= GAP;
                            ps2_data <= 1'b1;
                        end else begin
                            state    <= BIT_HI;
                            idx      <= idx + 1'b1;
                            ps2_data <= frame_bit(head, idx + 1'b1);
                        end
                    end else cnt <= cnt + 1'b1;
                    GAP: if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else cnt <= cnt + 1'b1;
                    HOLD: if (!inhibit) begin
                        state <= GAP;
                        cnt   <= '0;
                    end
                    default: begin
                        state    <= IDLE;
                        cnt      <= '0;
                        ps2_clk  <= 1'b1;
                        ps2_data <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/ps2_kbd_tx.md
Name: ps2_kbd_tx

Overview:
Device-side PS/2 transmitter that emulates a keyboard: it accepts scancode bytes through a valid/ready interface and serialises them as standard 11-bit PS/2 frames on generated ps2_clk/ps2_data lines. It is the counterpart to the ps2_keyboard receiver. Its outputs loop back directly into ps2_keyboard for on-board self-test without a physical keyboard. A small FIFO allows whole make/break sequences (e.g. 0x1C, 0xF0, 0x1C) to be queued back-to-back.

Parameters:
CLK_DIV, 1667, clk cycles per ps2_clk half-period (about 15 kHz at 50 MHz); must be >= 2
GAP_CYCLES, 3334, idle cycles, lines high, between frames and after an aborted frame
FIFO_DEPTH, 4, byte FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (0 = reset)
in_data  in  8  scancode byte to send
in_valid  in  1  in_data valid; accepted when in_valid & in_ready
in_ready  out  1  FIFO not full
inhibit  in  1  host holds clock low; 1 = inhibit
ps2_clk  out  1  generated PS/2 clock, idle 1
ps2_data  out  1  generated PS/2 data, idle 1
busy  out  1  FSM not in IDLE
frame_done  out  1  one-cycle pulse when a frame completes
fifo_count  out  $clog2(FIFO_DEPTH+1)  bytes queued, including the byte in flight

Behaviour:
- Reset (rst=0 at a clk edge), taking effect the next cycle:
  - ps2_clk=1, ps2_data=1, busy=0, frame_done=0.
  - FIFO emptied: fifo_count=0, in_ready=1.
  - FSM to IDLE; bit index and divider counter set to 0.
  - A frame in flight is dropped; lines return high immediately.
- Frame format, bit index 0..10:
  - 0: start bit = 0.
  - 1..8: data, LSB first.
  - 9: odd parity = ~^data.
  - 10: stop bit = 1.
- FSM states: IDLE, BIT_HI, BIT_LO, GAP, HOLD.
- IDLE:
  - Lines high.
  - If the FIFO is non-empty and inhibit=0 -> BIT_HI with index 0.
  - The FIFO head is not popped here.
- BIT_HI:
  - ps2_data = frame bit[index], ps2_clk=1, for CLK_DIV cycles -> BIT_LO.
- BIT_LO:
  - ps2_data holds, ps2_clk=0, for CLK_DIV cycles.
  - The receiver samples on the falling edge.
  - If index<10: index+1 -> BIT_HI.
  - If index=10: frame_done=1 on the last BIT_LO cycle, FIFO pops, -> GAP.
- GAP:
  - Lines high for GAP_CYCLES -> IDLE.
- Latency: a byte accepted at cycle N into an empty FIFO, with the FSM idle and inhibit=0, drives ps2_data=0 (start bit) from cycle N+2.
- Frame length: 22*CLK_DIV cycles from the first BIT_HI cycle to frame_done inclusive.
- Inhibit rules:
  - In IDLE or GAP, inhibit=1 holds off frame start. The GAP countdown still completes.
  - In BIT_HI/BIT_LO with index<=9, inhibit=1 aborts the frame: lines go high next cycle, state -> HOLD, FIFO not popped, no frame_done.
  - With index=10, inhibit is ignored and the frame completes normally.
  - HOLD: lines high; on inhibit=0 -> GAP, then the same byte is retransmitted from the start bit.
- FIFO:
  - in_ready = (fifo_count != FIFO_DEPTH), derived from registered count only.
  - A push and pop in the same cycle leave the count unchanged; both take effect.
  - When full, a push is not accepted, even if a pop occurs that cycle.
- Counters:
  - Divider counter counts 0..CLK_DIV-1, wraps, resets on every state change.
  - Bit index is 4 bits; only values 0..10 are used.
- busy=1 in every state except IDLE.
- Outputs ps2_clk and ps2_data are registered (glitch-free).

Decomposition:
- Shared package/header ps2_pkg:
  - FSM state encodings (IDLE, BIT_HI, BIT_LO, GAP, HOLD).
  - Frame constants: FRAME_BITS=11, START_BIT=0, STOP_BIT=1, PARITY_IDX=9.
  - Odd-parity function.
- Sub-module ps2_tx_fifo: synchronous byte FIFO with push/pop/count/full/empty, parameterised by FIFO_DEPTH.
- FSM, divider and shifter live in ps2_kbd_tx.

Test Plan:
Common settings: CLK_DIV=4, GAP_CYCLES=8; the ps2_keyboard receiver is attached for loopback.
1. Push 0x1C, no inhibit -> falling-edge samples 0,0,0,1,1,1,0,0,0,0,1 (parity 0); frame_done 88 cycles after first BIT_HI; receiver reports 0x1C.
2. Push 0x1C, 0xF0, 0x1C in consecutive cycles -> in_ready stays 1, fifo_count peaks at 3; three frames with 8-cycle gaps; receiver reports 0x1C, 0xF0, 0x1C; 0xF0 parity bit=1.
3. Push 5 bytes while the FSM is idle -> in_ready=0 once fifo_count=4; 5th byte held until the first pop, then accepted; all 5 bytes delivered in order.
4. Push 0x55; assert inhibit during bit 4 BIT_LO -> lines high next cycle, no frame_done, fifo_count=1; release inhibit -> 8 gap cycles, full 0x55 frame retransmitted.
5. Assert inhibit during stop bit (index 10) -> frame completes, frame_done pulses, FIFO pops.
6. rst=0 mid-frame with 2 bytes queued -> next cycle ps2_clk=1, ps2_data=1, busy=0, fifo_count=0, in_ready=1; no frame_done pulse.
